// File: rtl/pc_stack_pkg.sv
// ============================================================================
//  Module      : pc_stack_pkg
//  Description : Shared operation encoding, priority decode and level sizing
//                for the program-counter / return-stack block.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_stack_pkg;

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_INC  = 3'd1,
        OP_LOAD = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4
    } op_e;

    // Occupancy runs 0..depth inclusive, so one extra code point is needed.
    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic op_e decode_op(input logic ret, input logic call,
                                      input logic load, input logic inc);
        op_e v_op;
        v_op = OP_HOLD;
        if (ret)       v_op = OP_RET;
        else if (call) v_op = OP_CALL;
        else if (load) v_op = OP_LOAD;
        else if (inc)  v_op = OP_INC;
        return v_op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lifo_stack.sv
// ============================================================================
//  Module      : lifo_stack
//  Description : Return-address LIFO; push/pop are ignored when full/empty.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lifo_stack
    import pc_stack_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_push,
    input  logic                            i_pop,
    input  logic [WIDTH-1:0]                i_push_data,
    output logic [WIDTH-1:0]                o_top,
    output logic [level_width(DEPTH)-1:0]   o_level,
    output logic                            o_empty,
    output logic                            o_full
);

    localparam int c_LW = level_width(DEPTH);
    localparam int c_IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_LW-1:0]  r_level;
    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;
    logic [c_IW-1:0]  w_wr_idx;
    logic [c_IW-1:0]  w_top_idx;

    assign w_full    = (r_level == c_LW'(DEPTH));
    assign w_empty   = (r_level == '0);
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && !w_full && !i_pop;
    assign w_wr_idx  = c_IW'(r_level);
    assign w_top_idx = c_IW'(r_level - c_LW'(1));

    // Storage carries no reset: entries above the level are never visible.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_level <= '0;
        end else if (w_do_pop) begin
            r_level <= r_level - c_LW'(1);
        end else if (w_do_push) begin
            r_level <= r_level + c_LW'(1);
        end
    end

    assign o_top   = r_mem[w_top_idx];
    assign o_level = r_level;
    assign o_empty = w_empty;
    assign o_full  = w_full;

endmodule

`default_nettype wire

// File: rtl/pc_stack.sv
// ============================================================================
//  Module      : pc_stack
//  Description : Program counter with call/return stack and sticky error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_stack
    import pc_stack_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [WIDTH-1:0]                in,
    input  logic                            load,
    input  logic                            inc,
    input  logic                            call,
    input  logic                            ret,
    output logic [WIDTH-1:0]                out,
    output logic [level_width(DEPTH)-1:0]   level,
    output logic                            empty,
    output logic                            full,
    output logic                            err
);

    op_e              w_op;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic             w_full;
    logic [WIDTH-1:0] w_top;
    logic [WIDTH-1:0] w_out_plus1;
    logic [WIDTH-1:0] r_out;
    logic             r_err;

    assign w_op        = decode_op(ret, call, load, inc);
    assign w_out_plus1 = r_out + WIDTH'(1);
    assign w_push      = (w_op == OP_CALL) && !w_full;
    assign w_pop       = (w_op == OP_RET) && !w_empty;

    lifo_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (w_out_plus1),
        .o_top       (w_top),
        .o_level     (level),
        .o_empty     (w_empty),
        .o_full      (w_full)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out <= '0;
            r_err <= 1'b0;
        end else begin
            case (w_op)
                OP_RET: begin
                    if (w_empty) r_err <= 1'b1;
                    else         r_out <= w_top;
                end
                // A call into a full stack still jumps; only the push is lost.
                OP_CALL: begin
                    if (w_full) r_err <= 1'b1;
                    r_out <= in;
                end
                OP_LOAD: r_out <= in;
                OP_INC:  r_out <= w_out_plus1;
                default: r_out <= r_out;
            endcase
        end
    end

    assign out   = r_out;
    assign err   = r_err;
    assign empty = w_empty;
    assign full  = w_full;

endmodule

`default_nettype wire

// File: doc/pc_stack.md
PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 Parameter WIDTH, default 16, bit width of the counter, `in` and every stack entry.
REQ-002 Parameter DEPTH, default 8, number of return-address stack entries; DEPTH SHALL be at least 2.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 in  input  WIDTH  target address for load and call.
REQ-006 load  input  1  set counter to `in`.
REQ-007 inc  input  1  increment counter.
REQ-008 call  input  1  push return address, then jump to `in`.
REQ-009 ret  input  1  pop the stack into the counter.
REQ-010 out  output  WIDTH  registered counter value.
REQ-011 level  output  clog2(DEPTH+1)  number of occupied stack entries.
REQ-012 empty  output  1  high when level==0.
REQ-013 full  output  1  high when level==DEPTH.
REQ-014 err  output  1  sticky error flag.

Function
REQ-015 Command priority SHALL be ret > call > load > inc > hold, with exactly one operation per cycle.
REQ-016 Hold: with no command asserted, out, the stack and level SHALL be unchanged.
REQ-017 inc: out SHALL become (out+1) mod 2^WIDTH, so 2^WIDTH-1 wraps to 0.
REQ-018 load: out SHALL become `in`.
REQ-019 call, stack not full: stack[level] SHALL become (out+1) mod 2^WIDTH, level SHALL increment, and out SHALL become `in`.
REQ-020 call, stack full: out SHALL become `in`, there SHALL be no push, level SHALL be unchanged and err SHALL be set.
REQ-021 ret, stack not empty: out SHALL become stack[level-1] and level SHALL decrement.
REQ-022 ret, stack empty: out and level SHALL be unchanged and err SHALL be set.
REQ-023 call and ret in the same cycle SHALL behave as ret alone, per REQ-015.
REQ-024 All outputs SHALL be registered or decoded from registered state; a command sampled at edge N SHALL be visible on outputs after edge N, with one-cycle latency.
REQ-025 Stack contents above level SHALL be don't-care and SHALL NOT be observable.
REQ-026 err SHALL be cleared only by reset.

Reset
REQ-027 When rst_n is 0 at a rising edge, the block SHALL set out=0, level=0, empty=1, full=0 and err=0.
REQ-028 Reset SHALL take priority over every command, including mid-sequence call and ret.
REQ-029 Stack storage need not be cleared on reset; the next pop after reset SHALL still report empty per REQ-022.

Structure
REQ-030 A shared package SHALL hold the operation enum (OP_HOLD, OP_INC, OP_LOAD, OP_CALL, OP_RET) and the priority-decode function.
REQ-031 The level-width calculation SHALL live in the same package.
REQ-032 Stack storage and level SHALL be a single sub-module, lifo_stack (parameters WIDTH, DEPTH; push, pop, push data, top, level).
REQ-033 The counter register and priority decode SHALL stay in pc_stack.
REQ-034 The block SHALL contain no latches and no asynchronous logic.

Verification (WIDTH=16, DEPTH=4)
REQ-035 Reset, then inc for 3 cycles, then load with in=0x00F0 -> out reads 1, 2, 3, then 0x00F0; err=0 throughout.
REQ-036 out=0x0010, call with in=0x0200; call with in=0x0300; ret; ret -> out reads 0x0200, 0x0300, 0x0201, 0x0011; level reads 1, 2, 1, 0; empty=1 at the end.
REQ-037 Four calls filling the stack (full=1), then a fifth call with in=0x0ABC -> out=0x0ABC, level=4, err=1; four rets -> return addresses in LIFO order.
REQ-038 From reset, ret -> out=0, level=0, err=1; a later inc -> out=1 with err still 1.
REQ-039 Priority: out=0xFFFF with inc=1 -> out=0x0000; then call=1, ret=1, load=1, inc=1 together with one entry 0x1234 stacked -> out=0x1234, level=0.
REQ-040 Reset mid-stream: rst_n=0 for one edge with level=3 and load=1 -> out=0, level=0, err=0; the next ret sets err=1.
